// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters.
// It runs one operation at a time and returns RES/flags over a valid/ready response channel.
module alu_req_arbiter #(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int ALU_LAT = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ0_VALID,
  output logic            REQ0_READY,
  input  logic [DW-1:0]   REQ0_OPA,
  input  logic [DW-1:0]   REQ0_OPB,
  input  logic [CW-1:0]   REQ0_CMD,
  input  logic            REQ0_MODE,
  input  logic            REQ0_CIN,
  input  logic            REQ1_VALID,
  output logic            REQ1_READY,
  input  logic [DW-1:0]   REQ1_OPA,
  input  logic [DW-1:0]   REQ1_OPB,
  input  logic [CW-1:0]   REQ1_CMD,
  input  logic            REQ1_MODE,
  input  logic            REQ1_CIN,
  output logic            RSP0_VALID,
  input  logic            RSP0_READY,
  output logic            RSP1_VALID,
  input  logic            RSP1_READY,
  output logic [2*DW-1:0] RSP_RES,
  output logic [5:0]      RSP_FLAGS,
  output logic [DW-1:0]   ALU_OPA,
  output logic [DW-1:0]   ALU_OPB,
  output logic [CW-1:0]   ALU_CMD,
  output logic            ALU_MODE,
  output logic            ALU_CIN,
  output logic            ALU_CE,
  output logic [1:0]      ALU_INP_VALID,
  input  logic [2*DW-1:0] ALU_RES,
  input  logic            ALU_COUT,
  input  logic            ALU_OFLOW,
  input  logic            ALU_G,
  input  logic            ALU_E,
  input  logic            ALU_L,
  input  logic            ALU_ERR
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

  state_t        state, state_next;
  logic          ptr;
  logic          grant;
  logic          grant_q;
  logic          accept;
  logic          busy;
  logic [2:0]    cnt;
  logic [DW-1:0] opa_q, opb_q;
  logic [CW-1:0] cmd_q;
  logic          mode_q, cin_q;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    accept     = 1'b0;
    busy       = 1'b0;
    RSP0_VALID = 1'b0;
    RSP1_VALID = 1'b0;
    // The pointer only breaks ties; a lone requester always wins.
    grant = (REQ0_VALID && REQ1_VALID) ? ptr : REQ1_VALID;
    case (state)
      IDLE: begin
        REQ0_READY = !RST && REQ0_VALID && !grant;
        REQ1_READY = !RST && REQ1_VALID && grant;
        accept     = REQ0_READY || REQ1_READY;
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        busy       = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 3'd1) state_next = RESP;
      end
      RESP: begin
        RSP0_VALID = !grant_q;
        RSP1_VALID = grant_q;
        if (grant_q ? RSP1_READY : RSP0_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ALU_CE        = busy;
  assign ALU_INP_VALID = busy ? 2'b11 : 2'b00;
  assign ALU_OPA       = opa_q;
  assign ALU_OPB       = opb_q;
  assign ALU_CMD       = cmd_q;
  assign ALU_MODE      = mode_q;
  assign ALU_CIN       = cin_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      grant_q   <= 1'b0;
      cnt       <= 3'd0;
      opa_q     <= '0;
      opb_q     <= '0;
      cmd_q     <= '0;
      mode_q    <= 1'b0;
      cin_q     <= 1'b0;
      RSP_RES   <= '0;
      RSP_FLAGS <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (accept) begin
          // Toggling even for a lone requester is harmless; ties still alternate.
          ptr     <= ~ptr;
          grant_q <= grant;
          opa_q   <= grant ? REQ1_OPA  : REQ0_OPA;
          opb_q   <= grant ? REQ1_OPB  : REQ0_OPB;
          cmd_q   <= grant ? REQ1_CMD  : REQ0_CMD;
          mode_q  <= grant ? REQ1_MODE : REQ0_MODE;
          cin_q   <= grant ? REQ1_CIN  : REQ0_CIN;
        end
        ISSUE: cnt <= LAT_LOAD;
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            RSP_RES   <= ALU_RES;
            RSP_FLAGS <= {ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed testbench for alu_req_arbiter: an ALU_LAT=1 instance plus an ALU_LAT=3 instance.
// A small behavioural ALU with matching latency sits behind each instance.
module tb_alu_req_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Signals for the ALU_LAT=1 instance
  logic        REQ0_VALID = 0, REQ1_VALID = 0, REQ0_READY, REQ1_READY;
  logic [7:0]  REQ0_OPA = 0, REQ0_OPB = 0, REQ1_OPA = 0, REQ1_OPB = 0;
  logic [3:0]  REQ0_CMD = 0, REQ1_CMD = 0;
  logic        REQ0_MODE = 0, REQ0_CIN = 0, REQ1_MODE = 0, REQ1_CIN = 0;
  logic        RSP0_VALID, RSP1_VALID, RSP0_READY = 1, RSP1_READY = 1;
  logic [15:0] RSP_RES;
  logic [5:0]  RSP_FLAGS;
  logic [7:0]  ALU_OPA, ALU_OPB;
  logic [3:0]  ALU_CMD;
  logic        ALU_MODE, ALU_CIN, ALU_CE;
  logic [1:0]  ALU_INP_VALID;
  logic [15:0] ALU_RES;
  logic        ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;

  // Signals for the ALU_LAT=3 instance
  logic        B_REQ0_VALID = 0, B_REQ1_VALID = 0, B_REQ0_READY, B_REQ1_READY;
  logic [7:0]  B_REQ0_OPA = 0, B_REQ0_OPB = 0, B_REQ1_OPA = 0, B_REQ1_OPB = 0;
  logic [3:0]  B_REQ0_CMD = 0, B_REQ1_CMD = 0;
  logic        B_REQ0_MODE = 0, B_REQ0_CIN = 0, B_REQ1_MODE = 0, B_REQ1_CIN = 0;
  logic        B_RSP0_VALID, B_RSP1_VALID, B_RSP0_READY = 1, B_RSP1_READY = 1;
  logic [15:0] B_RSP_RES;
  logic [5:0]  B_RSP_FLAGS;
  logic [7:0]  B_ALU_OPA, B_ALU_OPB;
  logic [3:0]  B_ALU_CMD;
  logic        B_ALU_MODE, B_ALU_CIN, B_ALU_CE;
  logic [1:0]  B_ALU_INP_VALID;
  logic [15:0] B_ALU_RES;
  logic        B_ALU_COUT, B_ALU_OFLOW, B_ALU_G, B_ALU_E, B_ALU_L, B_ALU_ERR;

  alu_req_arbiter #(.DW(8), .CW(4), .ALU_LAT(1)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OPA(REQ0_OPA), .REQ0_OPB(REQ0_OPB),
    .REQ0_CMD(REQ0_CMD), .REQ0_MODE(REQ0_MODE), .REQ0_CIN(REQ0_CIN),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OPA(REQ1_OPA), .REQ1_OPB(REQ1_OPB),
    .REQ1_CMD(REQ1_CMD), .REQ1_MODE(REQ1_MODE), .REQ1_CIN(REQ1_CIN),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS),
    .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CMD(ALU_CMD), .ALU_MODE(ALU_MODE), .ALU_CIN(ALU_CIN),
    .ALU_CE(ALU_CE), .ALU_INP_VALID(ALU_INP_VALID), .ALU_RES(ALU_RES),
    .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW), .ALU_G(ALU_G), .ALU_E(ALU_E), .ALU_L(ALU_L), .ALU_ERR(ALU_ERR)
  );

  alu_req_arbiter #(.DW(8), .CW(4), .ALU_LAT(3)) dut_lat3 (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(B_REQ0_VALID), .REQ0_READY(B_REQ0_READY), .REQ0_OPA(B_REQ0_OPA), .REQ0_OPB(B_REQ0_OPB),
    .REQ0_CMD(B_REQ0_CMD), .REQ0_MODE(B_REQ0_MODE), .REQ0_CIN(B_REQ0_CIN),
    .REQ1_VALID(B_REQ1_VALID), .REQ1_READY(B_REQ1_READY), .REQ1_OPA(B_REQ1_OPA), .REQ1_OPB(B_REQ1_OPB),
    .REQ1_CMD(B_REQ1_CMD), .REQ1_MODE(B_REQ1_MODE), .REQ1_CIN(B_REQ1_CIN),
    .RSP0_VALID(B_RSP0_VALID), .RSP0_READY(B_RSP0_READY), .RSP1_VALID(B_RSP1_VALID), .RSP1_READY(B_RSP1_READY),
    .RSP_RES(B_RSP_RES), .RSP_FLAGS(B_RSP_FLAGS),
    .ALU_OPA(B_ALU_OPA), .ALU_OPB(B_ALU_OPB), .ALU_CMD(B_ALU_CMD), .ALU_MODE(B_ALU_MODE), .ALU_CIN(B_ALU_CIN),
    .ALU_CE(B_ALU_CE), .ALU_INP_VALID(B_ALU_INP_VALID), .ALU_RES(B_ALU_RES),
    .ALU_COUT(B_ALU_COUT), .ALU_OFLOW(B_ALU_OFLOW), .ALU_G(B_ALU_G), .ALU_E(B_ALU_E), .ALU_L(B_ALU_L), .ALU_ERR(B_ALU_ERR)
  );

  // Behavioural ALU: returns {res16, cout, oflow, g, e, l, err}
  function automatic logic [21:0] alu_calc(logic [7:0] a, logic [7:0] b, logic [3:0] cmd, logic mode, logic cin);
    logic [15:0] r;
    logic co, ov, er;
    r = '0; co = 0; ov = 0; er = 0;
    if (mode) begin
      case (cmd)
        4'd0: begin r = 16'(a) + 16'(b); co = r[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
        4'd1: begin r = 16'(a) - 16'(b); co = (a < b); ov = (a[7] != b[7]) && (r[7] != a[7]); end
        4'd2: begin r = 16'(a) + 16'(b) + 16'(cin); co = r[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
        default: er = 1;
      endcase
    end else begin
      case (cmd)
        4'd0: r = {8'h00, a & b};
        4'd1: r = {8'h00, a | b};
        4'd2: r = {8'h00, a ^ b};
        default: er = 1;
      endcase
    end
    return {r, co, ov, a > b, a == b, a < b, er};
  endfunction

  logic [21:0] alu_a_q = '0;
  always @(posedge CLK)
    if (ALU_CE && ALU_INP_VALID == 2'b11)
      alu_a_q <= alu_calc(ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN);
  assign {ALU_RES, ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR} = alu_a_q;

  logic [21:0] alu_b_q [3] = '{default: '0};
  always @(posedge CLK) begin
    if (B_ALU_CE && B_ALU_INP_VALID == 2'b11)
      alu_b_q[0] <= alu_calc(B_ALU_OPA, B_ALU_OPB, B_ALU_CMD, B_ALU_MODE, B_ALU_CIN);
    alu_b_q[1] <= alu_b_q[0];
    alu_b_q[2] <= alu_b_q[1];
  end
  assign {B_ALU_RES, B_ALU_COUT, B_ALU_OFLOW, B_ALU_G, B_ALU_E, B_ALU_L, B_ALU_ERR} = alu_b_q[2];

  // Waits (bounded) for a response on the LAT=1 instance; who=-1 on timeout
  task automatic wait_resp(output int who, output int cycles);
    who = -1;
    cycles = 0;
    for (int i = 0; i < 30 && who < 0; i++) begin
      @(negedge CLK);
      cycles++;
      if (RSP0_VALID) who = 0;
      else if (RSP1_VALID) who = 1;
    end
  endtask

  task automatic do_reset();
    RST = 1;
    repeat (2) @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    REQ0_VALID = 1; REQ1_VALID = 1; B_REQ0_VALID = 1;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_handshake: got %b expected 0000", {REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID});
    end
    checks++;
    if ({ALU_CE, ALU_INP_VALID} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_alu_ce: got %b expected 000", {ALU_CE, ALU_INP_VALID});
    end
    checks++;
    if ({RSP_RES, RSP_FLAGS} !== 22'h0) begin
      errors++; $display("[TB] FAIL reset_rsp: got %h expected 0", {RSP_RES, RSP_FLAGS});
    end
    checks++;
    if ({ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN} !== 22'h0) begin
      errors++; $display("[TB] FAIL reset_alu_pins: got %h expected 0", {ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN});
    end
    checks++;
    if ({B_REQ0_READY, B_RSP0_VALID, B_ALU_CE} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_lat3: got %b expected 000", {B_REQ0_READY, B_RSP0_VALID, B_ALU_CE});
    end
    REQ0_VALID = 0; REQ1_VALID = 0; B_REQ0_VALID = 0;
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic test_single_add();
    REQ0_OPA = 8'h05; REQ0_OPB = 8'h03; REQ0_CMD = 4'd0; REQ0_MODE = 1; REQ0_CIN = 0;
    REQ0_VALID = 1;
    #1;
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      errors++; $display("[TB] FAIL add_ready: got %b expected 10", {REQ0_READY, REQ1_READY});
    end
    @(negedge CLK);
    REQ0_VALID = 0;
    checks++;
    if ({ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_MODE} !== {3'b111, 8'h05, 8'h03, 1'b1}) begin
      errors++; $display("[TB] FAIL add_issue: got %h expected %h", {ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_MODE}, {3'b111, 8'h05, 8'h03, 1'b1});
    end
    @(negedge CLK);
    checks++;
    if ({ALU_CE, RSP0_VALID} !== 2'b10) begin
      errors++; $display("[TB] FAIL add_wait: got %b expected 10", {ALU_CE, RSP0_VALID});
    end
    @(negedge CLK);
    checks++;
    if ({RSP0_VALID, RSP1_VALID, ALU_CE, ALU_INP_VALID} !== 5'b10000) begin
      errors++; $display("[TB] FAIL add_resp_valid: got %b expected 10000", {RSP0_VALID, RSP1_VALID, ALU_CE, ALU_INP_VALID});
    end
    checks++;
    if ({RSP_RES, RSP_FLAGS} !== {16'h0008, 6'h08}) begin
      errors++; $display("[TB] FAIL add_result: got %h/%h expected 0008/08", RSP_RES, RSP_FLAGS);
    end
    @(negedge CLK);
    checks++;
    if ({RSP0_VALID, RSP1_VALID} !== 2'b00) begin
      errors++; $display("[TB] FAIL add_resp_drop: got %b expected 00", {RSP0_VALID, RSP1_VALID});
    end
  endtask

  task automatic test_fairness();
    int who, cyc, exp_who;
    do_reset();
    REQ0_OPA = 8'h01; REQ0_OPB = 8'h01; REQ0_CMD = 4'd0; REQ0_MODE = 1; REQ0_CIN = 0;
    REQ1_OPA = 8'h02; REQ1_OPB = 8'h02; REQ1_CMD = 4'd0; REQ1_MODE = 1; REQ1_CIN = 0;
    REQ0_VALID = 1; REQ1_VALID = 1;
    for (int k = 0; k < 4; k++) begin
      exp_who = k % 2;
      wait_resp(who, cyc);
      checks++;
      if (who !== exp_who) begin
        errors++; $display("[TB] FAIL fair_order op%0d: got %0d expected %0d", k, who, exp_who);
      end
      checks++;
      if (RSP_RES !== (exp_who == 1 ? 16'h0004 : 16'h0002)) begin
        errors++; $display("[TB] FAIL fair_result op%0d: got %h expected %h", k, RSP_RES, (exp_who == 1 ? 16'h0004 : 16'h0002));
      end
      if (k > 0) begin
        checks++;
        if (cyc !== 4) begin
          errors++; $display("[TB] FAIL back_to_back op%0d: got %0d cycles expected 4", k, cyc);
        end
      end
    end
    REQ0_VALID = 0; REQ1_VALID = 0;
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    int who, cyc;
    RSP1_READY = 0;
    REQ1_OPA = 8'h10; REQ1_OPB = 8'h20; REQ1_CMD = 4'd0; REQ1_MODE = 1; REQ1_CIN = 0;
    REQ1_VALID = 1;
    wait_resp(who, cyc);
    REQ1_VALID = 0;
    REQ0_OPA = 8'h07; REQ0_OPB = 8'h0C; REQ0_CMD = 4'd0; REQ0_MODE = 0; REQ0_CIN = 0;
    REQ0_VALID = 1;
    checks++;
    if (who !== 1) begin
      errors++; $display("[TB] FAIL hold_grant: got %0d expected 1", who);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({RSP1_VALID, RSP0_VALID, REQ0_READY, REQ1_READY, RSP_RES, RSP_FLAGS} !== {4'b1000, 16'h0030, 6'h02}) begin
        errors++; $display("[TB] FAIL hold_stable cyc%0d: got %h expected %h", i,
                           {RSP1_VALID, RSP0_VALID, REQ0_READY, REQ1_READY, RSP_RES, RSP_FLAGS}, {4'b1000, 16'h0030, 6'h02});
      end
      @(negedge CLK);
    end
    RSP1_READY = 1;
    #1;
    checks++;
    if (REQ0_READY !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_release_early: got %b expected 0", REQ0_READY);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({REQ0_READY, RSP1_VALID} !== 2'b10) begin
      errors++; $display("[TB] FAIL hold_next_accept: got %b expected 10", {REQ0_READY, RSP1_VALID});
    end
    @(negedge CLK);
    REQ0_VALID = 0;
    wait_resp(who, cyc);
    checks++;
    if ({who[1:0], RSP_RES} !== {2'd0, 16'h0004}) begin
      errors++; $display("[TB] FAIL hold_followup: got %0d/%h expected 0/0004", who, RSP_RES);
    end
    @(negedge CLK);
  endtask

  task automatic test_add_cin();
    int who, cyc;
    REQ1_OPA = 8'hFF; REQ1_OPB = 8'h01; REQ1_CMD = 4'd2; REQ1_MODE = 1; REQ1_CIN = 1;
    REQ1_VALID = 1;
    wait_resp(who, cyc);
    REQ1_VALID = 0;
    checks++;
    if (who !== 1) begin
      errors++; $display("[TB] FAIL cin_grant: got %0d expected 1", who);
    end
    checks++;
    if (RSP_RES !== 16'h0101) begin
      errors++; $display("[TB] FAIL cin_result: got %h expected 0101", RSP_RES);
    end
    checks++;
    if (RSP_FLAGS[5] !== 1'b1) begin
      errors++; $display("[TB] FAIL cin_cout: got %b expected 1", RSP_FLAGS[5]);
    end
    checks++;
    if (RSP_FLAGS !== 6'h28) begin
      errors++; $display("[TB] FAIL cin_flags: got %h expected 28", RSP_FLAGS);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_op();
    int who, cyc;
    logic seen_rsp;
    REQ1_OPA = 8'h03; REQ1_OPB = 8'h04; REQ1_CMD = 4'd0; REQ1_MODE = 1; REQ1_CIN = 0;
    REQ1_VALID = 1;
    @(negedge CLK);
    REQ1_VALID = 0;
    @(negedge CLK);
    checks++;
    if (ALU_CE !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_in_wait: got %b expected 1", ALU_CE);
    end
    RST = 1;
    @(negedge CLK);
    RST = 0;
    checks++;
    if ({ALU_CE, ALU_INP_VALID, RSP0_VALID, RSP1_VALID, RSP_RES} !== 21'h0) begin
      errors++; $display("[TB] FAIL abort_idle: got %h expected 0", {ALU_CE, ALU_INP_VALID, RSP0_VALID, RSP1_VALID, RSP_RES});
    end
    seen_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      seen_rsp = seen_rsp | RSP0_VALID | RSP1_VALID;
    end
    checks++;
    if (seen_rsp !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_no_rsp: got %b expected 0", seen_rsp);
    end
    REQ0_OPA = 8'h09; REQ0_OPB = 8'h01; REQ0_CMD = 4'd0; REQ0_MODE = 1; REQ0_CIN = 0;
    REQ0_VALID = 1; REQ1_VALID = 1;
    #1;
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      errors++; $display("[TB] FAIL abort_ptr: got %b expected 10", {REQ0_READY, REQ1_READY});
    end
    wait_resp(who, cyc);
    REQ0_VALID = 0; REQ1_VALID = 0;
    checks++;
    if ({who[1:0], RSP_RES} !== {2'd0, 16'h000A}) begin
      errors++; $display("[TB] FAIL abort_next_op: got %0d/%h expected 0/000a", who, RSP_RES);
    end
    @(negedge CLK);
  endtask

  task automatic test_lat3_err();
    int ce_cycles, first_rsp;
    logic [5:0]  flags_seen;
    logic [15:0] res_seen;
    ce_cycles = 0; first_rsp = -1; flags_seen = '0; res_seen = 16'hFFFF;
    B_REQ0_OPA = 8'h10; B_REQ0_OPB = 8'h10; B_REQ0_CMD = 4'd15; B_REQ0_MODE = 1; B_REQ0_CIN = 0;
    B_REQ0_VALID = 1;
    #1;
    checks++;
    if (B_REQ0_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL lat3_ready: got %b expected 1", B_REQ0_READY);
    end
    @(negedge CLK);
    B_REQ0_VALID = 0;
    for (int i = 1; i <= 6; i++) begin
      if (B_ALU_CE) ce_cycles++;
      if (first_rsp < 0 && B_RSP0_VALID) begin
        first_rsp  = i;
        flags_seen = B_RSP_FLAGS;
        res_seen   = B_RSP_RES;
      end
      @(negedge CLK);
    end
    checks++;
    if (ce_cycles !== 4) begin
      errors++; $display("[TB] FAIL lat3_ce_cycles: got %0d expected 4", ce_cycles);
    end
    checks++;
    if (first_rsp !== 5) begin
      errors++; $display("[TB] FAIL lat3_rsp_time: got T+%0d expected T+5", first_rsp);
    end
    checks++;
    if (flags_seen[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL lat3_err_flag: got %b expected 1", flags_seen[0]);
    end
    checks++;
    if ({res_seen, flags_seen} !== {16'h0000, 6'h05}) begin
      errors++; $display("[TB] FAIL lat3_result: got %h/%h expected 0000/05", res_seen, flags_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fairness();
    test_backpressure();
    test_add_cin();
    test_reset_mid_op();
    test_lat3_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
